pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the single-cycle RISC-V (RV32I + C) core, replacing the fixed combinational PC+4 adder. It holds the architectural PC register, computes the sequential successor as +2 or +4 from the fetched instruction's length bits, and applies stalls and branch/jump redirects. Misaligned redirect targets are diverted to a trap vector. It also keeps a retired-advance counter. It sits between the instruction memory (which consumes `o_pc`) and the branch/jump resolution logic (which drives `i_redirect` and `i_target`).

## Interface
- `PC_W`, 32: PC and target width, in bits.
- `CNT_W`, 32: width of the advance counter.
- `RESET_VECTOR`, 32'h0000_0000: PC value loaded on reset.
- `TRAP_VECTOR`, 32'h0000_0100: PC value loaded on a misaligned redirect.

Ports (name, direction, width, meaning):
- `i_clk`, in, 1: the single clock; all state updates on its rising edge.
- `i_rst_n`, in, 1: synchronous, active-low reset.
- `i_stall`, in, 1: hold the PC this cycle.
- `i_redirect`, in, 1: a branch/jump is taken this cycle.
- `i_target`, in, `PC_W`: redirect destination address.
- `i_instr_lo`, in, 2: bits [1:0] of the instruction at `o_pc`.
- `o_pc`, out, `PC_W`: current PC (registered).
- `o_pc_seq`, out, `PC_W`: `o_pc` + instruction length (combinational); used as the JAL/JALR link value.
- `o_boot`, out, 1: high during the BOOT cycle.
- `o_trap`, out, 1: high during the TRAP cycle.
- `o_trap_addr`, out, `PC_W`: the offending target of the most recent trap.
- `o_instret`, out, `CNT_W`: count of PC advances.

## Operation
- **Instruction length:**
  - `inc` = 2 when compressed support is compiled in and `i_instr_lo != 2'b11`; otherwise `inc` = 4.
  - `o_pc_seq = o_pc + inc`, modulo 2^`PC_W`. 32'hFFFF_FFFC + 4 wraps to 0.
- **Alignment:**
  - `misalign` = `i_target[0]` when compressed support is compiled in.
  - `misalign` = `|i_target[1:0]` when compressed support is compiled out.
- **State machine** (states BOOT, RUN, TRAP):
  - **BOOT:** entered on reset. PC holds `RESET_VECTOR`, all inputs are ignored, `o_boot` = 1. Goes to RUN on the next edge.
  - **RUN:** next-PC priority is misaligned redirect > redirect > stall > sequential.
    - `i_redirect` && `misalign`: PC ← `TRAP_VECTOR`, `o_trap_addr` ← `i_target`, go to TRAP.
    - `i_redirect` && !`misalign`: PC ← `i_target`; the redirect overrides `i_stall`.
    - `i_stall`: PC holds.
    - otherwise: PC ← `o_pc_seq`.
  - **TRAP:** one cycle. PC holds `TRAP_VECTOR`, `o_trap` = 1, all inputs are ignored. Goes to RUN on the next edge.
- **Advance counter:**
  - `o_instret` increments by 1 on every RUN-state edge whose PC load is a valid redirect or a sequential step.
  - It does not increment on stall, on trap entry, in BOOT or in TRAP.
  - It wraps modulo 2^`CNT_W`.

## Timing
- **Reset:** when `i_rst_n` = 0 at an edge, the edge gives:
  - state = BOOT, `o_pc` = `RESET_VECTOR`, `o_boot` = 1
  - `o_trap` = 0, `o_trap_addr` = 0, `o_instret` = 0
- **Reset mid-operation:** reset wins over every other input, including a pending redirect or an active TRAP.
- **Latency:** redirect, stall and step decisions are sampled at edge N. The resulting `o_pc` is visible after edge N. `o_pc_seq` follows `i_instr_lo` combinationally within the same cycle.
- **Post-reset sequence:** after reset is released there is exactly one BOOT cycle, so the first RUN fetch is at `RESET_VECTOR`.
- **Trap sequence:** `o_trap` is high for exactly one cycle, beginning the cycle after the edge that sampled the misaligned redirect.
- **Back-to-back redirects:** each redirect is honoured on consecutive cycles; there is no bubble.

## Configuration
- **`PC_COMPRESSED_EN` defined:** RV32C support. Variable +2/+4 stepping and 2-byte alignment check.
- **`PC_COMPRESSED_EN` undefined:**
  - `inc` is always 4 and `i_instr_lo` is ignored.
  - Targets must be 4-byte aligned.
  - A target of 32'h0000_0012 traps.

## Test plan
- **Reset and boot:** hold `i_rst_n` = 0 for 2 cycles, then release with `RESET_VECTOR` = 0.
  - Required: `o_boot` = 1 for one cycle with `o_pc` = 0.
  - Then, with `i_instr_lo` = 2'b11, `o_pc` = 0 → 4 → 8, and `o_instret` = 2.
- **Compressed stepping** (`PC_COMPRESSED_EN` defined): from `o_pc` = 32'h10, apply `i_instr_lo` = 2'b01, 2'b11, 2'b10.
  - Required: `o_pc` = 0x12, then 0x16, then 0x18.
- **Redirect vs. stall:** at `o_pc` = 32'h20, assert `i_stall` = 1 for 2 cycles.
  - Required: PC holds at 0x20 and `o_instret` is unchanged.
  - Then assert `i_stall` = 1 together with `i_redirect` = 1, `i_target` = 32'h400. Required: `o_pc` = 0x400.
- **Misaligned target:** assert `i_redirect` with `i_target` = 32'h401.
  - Required: `o_pc` = 32'h100, `o_trap` = 1 for exactly one cycle, `o_trap_addr` = 32'h401.
  - Required: a redirect presented during the TRAP cycle is ignored.
  - Required: `o_instret` is unchanged across the trap.
- **Wrap-around:** redirect to 32'hFFFF_FFFC, then step with `i_instr_lo` = 2'b11.
  - Required: `o_pc` = 0 and `o_pc_seq` = 4.
- **Reset mid-trap:** assert `i_rst_n` = 0 during the TRAP cycle.
  - Required: the next cycle shows `o_pc` = `RESET_VECTOR`, `o_trap` = 0, `o_boot` = 1.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the single-cycle RV32I(+C) core.
// Holds the architectural PC, steps it by the fetched instruction length,
// applies stalls and branch/jump redirects, diverts misaligned redirect
// targets to a trap vector, and counts retired PC advances.
//
// Optional feature macro: PC_COMPRESSED_EN
//   defined   : RV32C support, +2/+4 stepping, 2-byte target alignment.
//   undefined : fixed +4 stepping, 4-byte target alignment, i_instr_lo unused.
module pc_gen #(
  parameter int unsigned     PC_W         = 32,
  parameter int unsigned     CNT_W        = 32,
  parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [PC_W-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [PC_W-1:0]  i_target,
  input  logic [1:0]       i_instr_lo,
  output logic [PC_W-1:0]  o_pc,
  output logic [PC_W-1:0]  o_pc_seq,
  output logic             o_boot,
  output logic             o_trap,
  output logic [PC_W-1:0]  o_trap_addr,
  output logic [CNT_W-1:0] o_instret
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TRAP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_nxt;
  logic [PC_W-1:0]  trap_addr;
  logic [PC_W-1:0]  trap_addr_nxt;
  logic [CNT_W-1:0] instret;
  logic             advance;
  logic [PC_W-1:0]  inc;
  logic [PC_W-1:0]  pc_seq;
  logic             misalign;

`ifdef PC_COMPRESSED_EN
  // Instruction length from the low opcode bits; alignment only needs bit 0.
  always_comb begin
    inc      = (i_instr_lo != 2'b11) ? PC_W'(2) : PC_W'(4);
    misalign = i_target[0];
  end
`else
  logic unused_instr_lo;
  assign unused_instr_lo = ^i_instr_lo;

  // Fixed 32-bit instructions; targets must be word aligned.
  always_comb begin
    inc      = PC_W'(4);
    misalign = |i_target[1:0];
  end
`endif

  // Sequential successor, wraps modulo 2^PC_W; doubles as the link value.
  always_comb begin
    pc_seq = pc + inc;
  end

  // Next-state/next-PC selection: misaligned redirect > redirect > stall > step.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    trap_addr_nxt = trap_addr;
    advance       = 1'b0;
    case (state)
      ST_BOOT: begin
        state_nxt = ST_RUN;
        pc_nxt    = RESET_VECTOR;
      end
      ST_TRAP: begin
        state_nxt = ST_RUN;
        pc_nxt    = TRAP_VECTOR;
      end
      ST_RUN: begin
        if (i_redirect && misalign) begin
          state_nxt     = ST_TRAP;
          pc_nxt        = TRAP_VECTOR;
          trap_addr_nxt = i_target;
        end else if (i_redirect) begin
          pc_nxt  = i_target;
          advance = 1'b1;
        end else if (!i_stall) begin
          pc_nxt  = pc_seq;
          advance = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: recover through BOOT.
        state_nxt = ST_BOOT;
        pc_nxt    = RESET_VECTOR;
      end
    endcase
  end

  // Architectural PC, state and trap-address registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_BOOT;
      pc        <= RESET_VECTOR;
      trap_addr <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      trap_addr <= trap_addr_nxt;
    end
  end

  // Retired-advance counter: valid redirects and sequential steps only.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      instret <= '0;
    end else if (advance) begin
      instret <= instret + CNT_W'(1);
    end
  end

  // Output mapping.
  always_comb begin
    o_pc        = pc;
    o_pc_seq    = pc_seq;
    o_boot      = (state == ST_BOOT);
    o_trap      = (state == ST_TRAP);
    o_trap_addr = trap_addr;
    o_instret   = instret;
  end

endmodule
